// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the fetch/load-store memory arbiter: response tags,
// default bus widths and word-addressing constants.
package imem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RESP_IF = 2'd1,
      RESP_LS = 2'd2
   } resp_tag_t;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned WORD_SHIFT = 2;
   localparam int unsigned STREAK_W   = 4;

   localparam logic [DATA_W_DEF/8-1:0] BE_ALL = '1;

endpackage

// File: rtl/imem_arbiter_if.sv
// Bundle of the fetch port, load/store port and memory port seen by the arbiter.
// slave = arbiter view; master = CPU stages plus RAM.
interface imem_arbiter_if
   import imem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) ();

   logic                       if_req;
   logic [ADDR_W-1:0]          if_addr;
   logic                       if_gnt;
   logic                       if_rvalid;
   logic [DATA_W-1:0]          if_rdata;

   logic                       ls_req;
   logic                       ls_we;
   logic [DATA_W/8-1:0]        ls_be;
   logic [ADDR_W-1:0]          ls_addr;
   logic [DATA_W-1:0]          ls_wdata;
   logic                       ls_gnt;
   logic                       ls_rvalid;
   logic [DATA_W-1:0]          ls_rdata;

   logic                       mem_en;
   logic                       mem_we;
   logic [DATA_W/8-1:0]        mem_be;
   logic [ADDR_W-WORD_SHIFT-1:0] mem_addr;
   logic [DATA_W-1:0]          mem_wdata;
   logic [DATA_W-1:0]          mem_rdata;

   modport slave (
      input  if_req, if_addr,
      input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
      input  mem_rdata,
      output if_gnt, if_rvalid, if_rdata,
      output ls_gnt, ls_rvalid, ls_rdata,
      output mem_en, mem_we, mem_be, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr,
      output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
      output mem_rdata,
      input  if_gnt, if_rvalid, if_rdata,
      input  ls_gnt, ls_rvalid, ls_rdata,
      input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
   );

endinterface

// File: rtl/imem_arbiter.sv
// Two-port arbiter for a single-port synchronous RAM: load/store wins by default,
// fetch is forced through after STARVE_LIMIT consecutive load/store grants.
module imem_arbiter
   import imem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W       = ADDR_W_DEF,
   parameter int unsigned DATA_W       = DATA_W_DEF,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic            clk,
   input logic            rst,
   imem_arbiter_if.slave  bus
);

   localparam int unsigned         BE_W  = DATA_W / 8;
   localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

   resp_tag_t             tag_q, tag_d;
   logic [STREAK_W-1:0]   streak_q, streak_d;
   logic                  we_q, we_d;

   logic                  if_win;
   logic                  if_gnt;
   logic                  ls_gnt;

   // Address LSBs are deliberately ignored: all accesses are whole words.
   logic                  unused_addr_lsbs;
   assign unused_addr_lsbs = ^{bus.if_addr[WORD_SHIFT-1:0], bus.ls_addr[WORD_SHIFT-1:0]};

   // Grant: purely combinational from request lines and the streak counter.
   always_comb begin
      if_win = bus.if_req && (streak_q == LIMIT);
      ls_gnt = !rst && bus.ls_req && !if_win;
      if_gnt = !rst && bus.if_req && !ls_gnt;
   end

   always_comb begin
      streak_d = streak_q;
      if (if_gnt || !bus.if_req) begin
         streak_d = '0;
      end else if (ls_gnt && (streak_q < LIMIT)) begin
         streak_d = streak_q + STREAK_W'(1);
      end
   end

   always_comb begin
      tag_d = IDLE;
      if (if_gnt) begin
         tag_d = RESP_IF;
      end else if (ls_gnt) begin
         tag_d = RESP_LS;
      end
      we_d = ls_gnt && bus.ls_we;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_q    <= IDLE;
         streak_q <= '0;
         we_q     <= 1'b0;
      end else begin
         tag_q    <= tag_d;
         streak_q <= streak_d;
         we_q     <= we_d;
      end
   end

   // Memory port: steered from whichever requester holds the grant, zero otherwise.
   always_comb begin
      bus.mem_en    = if_gnt || ls_gnt;
      bus.mem_we    = 1'b0;
      bus.mem_be    = '0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (ls_gnt) begin
         bus.mem_we   = bus.ls_we;
         bus.mem_be   = bus.ls_we ? bus.ls_be : {BE_W{1'b1}};
         bus.mem_addr = bus.ls_addr[ADDR_W-1:WORD_SHIFT];
         if (bus.ls_we) begin
            bus.mem_wdata = bus.ls_wdata;
         end
      end else if (if_gnt) begin
         bus.mem_be   = {BE_W{1'b1}};
         bus.mem_addr = bus.if_addr[ADDR_W-1:WORD_SHIFT];
      end
   end

   // Responses: a reset in the cycle after a grant suppresses the in-flight rvalid.
   always_comb begin
      bus.if_gnt    = if_gnt;
      bus.ls_gnt    = ls_gnt;
      bus.if_rvalid = !rst && (tag_q == RESP_IF);
      bus.ls_rvalid = !rst && (tag_q == RESP_LS);
      bus.if_rdata  = '0;
      bus.ls_rdata  = '0;
      if (bus.if_rvalid) begin
         bus.if_rdata = bus.mem_rdata;
      end
      if (bus.ls_rvalid && !we_q) begin
         bus.ls_rdata = bus.mem_rdata;
      end
   end

   a_gnt_onehot : assert property (@(posedge clk) !(bus.if_gnt && bus.ls_gnt));
   a_streak_max : assert property (@(posedge clk) streak_q <= LIMIT);

endmodule
